// File: rtl/fft8_input_reorder.sv
// Input stage of the 8-point FFT: collects one complex sample per cycle into
// bit-reversed slots and presents the whole frame in parallel to the first butterfly rank.
module fft8_input_reorder #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_real,
  output logic [N*DW-1:0] out_imag,
  output logic            sync_err
);

  generate
    if (N != 8) begin : gBadN
      $error("fft8_input_reorder supports only N == 8");
    end
  endgenerate

  typedef enum logic {FILL, FULL} state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [2:0]    r_wrCnt;
  logic          r_syncErr;
  logic [DW-1:0] r_bufReal [N];
  logic [DW-1:0] r_bufImag [N];

  logic          w_accept;
  logic [2:0]    w_idx;
  logic [2:0]    w_slot;

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == FULL);
  assign sync_err  = r_syncErr;

  assign w_accept = in_valid && in_ready;
  // A flagged first sample always restarts the frame at index 0, abandoning any partial fill.
  assign w_idx    = in_first ? 3'd0 : r_wrCnt;
  assign w_slot   = {w_idx[0], w_idx[1], w_idx[2]};

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      FILL: if (w_accept && (w_idx == 3'd7)) w_stateNext = FULL;
      FULL: if (out_ready) w_stateNext = FILL;
      default: w_stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_wrCnt   <= 3'd0;
      r_syncErr <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_bufReal[k] <= '0;
        r_bufImag[k] <= '0;
      end
    end else begin
      r_state   <= w_stateNext;
      r_syncErr <= w_accept && in_first && (r_wrCnt != 3'd0);
      if (w_accept) begin
        r_bufReal[w_slot] <= in_real;
        r_bufImag[w_slot] <= in_imag;
        r_wrCnt           <= w_idx + 3'd1;
      end
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : gPack
      assign out_real[DW*k +: DW] = r_bufReal[k];
      assign out_imag[DW*k +: DW] = r_bufImag[k];
    end
  endgenerate

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Directed self-checking bench for fft8_input_reorder: framing, back-pressure,
// resynchronisation, reset, bit-exact special values and throughput.
module tb_fft8_input_reorder;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int BITREV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  localparam logic [31:0] FLT [8] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                                      32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_first;
  logic [DW-1:0]   in_real;
  logic [DW-1:0]   in_imag;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_real;
  logic [N*DW-1:0] out_imag;
  logic            sync_err;

  int errors = 0;
  int checks = 0;

  logic [N*DW-1:0] expReal;
  logic [N*DW-1:0] expImag;
  int pulseCount;
  int pulseAt [4];

  fft8_input_reorder #(.DW(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch with both values.
  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then lands 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic first, input logic [31:0] re, input logic [31:0] im);
    in_valid = v;
    in_first = first;
    in_real  = re;
    in_imag  = im;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slotOf(input logic [N*DW-1:0] bus, input int k);
    return bus[DW*k +: DW];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sync_err", sync_err, 0);
    checkOutput("rst_out_real", out_real, 0);
    checkOutput("rst_out_imag", out_imag, 0);

    // Frame of real k / imag -k, first sample flagged
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, k == 0, FLT[k], FLT[k] | 32'h80000000);
      if (k < 7) checkOutput("f1_no_early_valid", out_valid, 0);
    end
    in_valid = 0; in_first = 0;
    checkOutput("f1_out_valid", out_valid, 1);
    checkOutput("f1_in_ready", in_ready, 0);
    checkOutput("f1_sync_err", sync_err, 0);
    checkOutput("f1_slot1_real", slotOf(out_real, 1), 32'h40800000);
    checkOutput("f1_slot1_imag", slotOf(out_imag, 1), 32'hC0800000);
    checkOutput("f1_slot6_real", slotOf(out_real, 6), 32'h40400000);
    checkOutput("f1_slot0_imag", slotOf(out_imag, 0), 32'h80000000);
    checkOutput("f1_slot7_real", slotOf(out_real, 7), 32'h40E00000);
    applyStimulus(0, 0, 0, 0);
    checkOutput("f1_valid_drop", out_valid, 0);
    checkOutput("f1_ready_rise", in_ready, 1);

    // Back-pressure: frame held while upstream keeps pushing
    out_ready = 0;
    expReal = '0; expImag = '0;
    for (int k = 0; k < 8; k++) begin
      expReal[DW*BITREV[k] +: DW] = 32'h100 + k;
      expImag[DW*BITREV[k] +: DW] = 32'h200 + k;
      applyStimulus(1, 0, 32'h100 + k, 32'h200 + k);
    end
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_real", out_real, expReal);
      checkOutput("bp_out_imag", out_imag, expImag);
      applyStimulus(1, 1, 32'hDEADBEEF, 32'hCAFEF00D);
      checkOutput("bp_sync_err", sync_err, 0);
    end
    in_valid = 0; in_first = 0;
    out_ready = 1;
    applyStimulus(0, 0, 0, 0);
    out_ready = 0;
    checkOutput("bp_release_ready", in_ready, 1);
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_retained", out_real, expReal);
    out_ready = 1;

    // Resync after 5 samples of a partial frame
    for (int k = 0; k < 5; k++) applyStimulus(1, k == 0, 32'h11 + k, 32'h21 + k);
    applyStimulus(1, 1, 32'hAA, 32'hBB);
    checkOutput("rs_sync_err", sync_err, 1);
    checkOutput("rs_slot0_real", slotOf(out_real, 0), 32'hAA);
    checkOutput("rs_slot0_imag", slotOf(out_imag, 0), 32'hBB);
    checkOutput("rs_stale_slot4", slotOf(out_real, 4), 32'h12);
    for (int k = 1; k < 8; k++) begin
      applyStimulus(1, 0, 32'h30 + k, 32'h40 + k);
      if (k == 1) checkOutput("rs_sync_err_pulse", sync_err, 0);
      if (k < 7) checkOutput("rs_no_early_valid", out_valid, 0);
    end
    in_valid = 0;
    checkOutput("rs_out_valid", out_valid, 1);
    expReal = '0;
    expReal[31:0] = 32'hAA;
    for (int k = 1; k < 8; k++) expReal[DW*BITREV[k] +: DW] = 32'h30 + k;
    checkOutput("rs_frame_real", out_real, expReal);
    applyStimulus(0, 0, 0, 0);

    // Mid-fill reset discards the partial frame and the counter
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 32'h51 + k, 32'h55);
    in_valid = 0;
    rst = 1;
    applyStimulus(0, 0, 0, 0);
    rst = 0;
    checkOutput("mr_out_real", out_real, 0);
    checkOutput("mr_out_imag", out_imag, 0);
    checkOutput("mr_in_ready", in_ready, 1);
    checkOutput("mr_out_valid", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 32'h61 + k, 32'h71 + k);
      if (k < 7) checkOutput("mr_no_early_valid", out_valid, 0);
    end
    in_valid = 0;
    checkOutput("mr_out_valid_after8", out_valid, 1);
    checkOutput("mr_slot4_real", slotOf(out_real, 4), 32'h62);
    applyStimulus(0, 0, 0, 0);

    // Special float patterns pass through bit-exact
    for (int k = 0; k < 8; k++) begin
      case (k)
        3: applyStimulus(1, 0, 32'h7FC00000, 32'hFF800000);
        5: applyStimulus(1, 0, 32'h80000000, 32'h00000001);
        6: applyStimulus(1, 0, 32'h00000001, 32'h80000000);
        7: applyStimulus(1, 0, 32'hFF800000, 32'h7FC00000);
        default: applyStimulus(1, 0, 32'h0, 32'h0);
      endcase
    end
    in_valid = 0;
    checkOutput("sv_out_valid", out_valid, 1);
    checkOutput("sv_slot6_real", slotOf(out_real, 6), 32'h7FC00000);
    checkOutput("sv_slot5_real", slotOf(out_real, 5), 32'h80000000);
    checkOutput("sv_slot3_real", slotOf(out_real, 3), 32'h00000001);
    checkOutput("sv_slot7_real", slotOf(out_real, 7), 32'hFF800000);
    checkOutput("sv_slot6_imag", slotOf(out_imag, 6), 32'hFF800000);
    checkOutput("sv_slot3_imag", slotOf(out_imag, 3), 32'h80000000);
    applyStimulus(0, 0, 0, 0);

    // Throughput: 4 frames streamed with both handshakes held high
    pulseCount = 0;
    for (int i = 0; i < 4; i++) pulseAt[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1, 0, c, c);
      if (out_valid) begin
        if (pulseCount < 4) pulseAt[pulseCount] = c;
        pulseCount++;
      end
    end
    in_valid = 0;
    checkOutput("tp_pulse_count", pulseCount, 4);
    checkOutput("tp_first_pulse", pulseAt[0], 8);
    for (int i = 1; i < 4; i++) checkOutput("tp_pulse_gap", pulseAt[i] - pulseAt[i-1], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
